// File: rtl/dmux4way_pkg.sv
// dmux4way_pkg: shared channel constants, dispatcher state type and select decode
package dmux4way_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] s);
    return NUM_CH'(1) << s;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first enabled channel at or after ptr, wrapping modulo 4
module rr_pick4
  import dmux4way_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] en,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);
  // scan farthest-first so the nearest enabled channel wins
  always_comb begin
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (en[ptr + SEL_W'(k)]) pick = ptr + SEL_W'(k);
  end
  assign any = |en;
endmodule

// File: rtl/dmux4way_dispatch.sv
// dmux4way_dispatch: round-robin 1-to-4 dispatcher with a one-entry holding register
// Optional per-channel saturating delivery counters under DMUX4WAY_DISPATCH_CNT_EN.
module dmux4way_dispatch
  import dmux4way_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] cfg_en,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              in_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [W-1:0]      out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [SEL_W-1:0]  out_sel,
  output logic              busy
`ifdef DMUX4WAY_DISPATCH_CNT_EN
  ,
  output logic [NUM_CH*CW-1:0] beat_cnt,
  input  logic                 cnt_clr
`endif
);
  state_t r_state, w_nstate;
  logic [SEL_W-1:0] r_ptr, r_tgt, w_pick;
  logic [W-1:0] r_data;
  logic w_any, w_accept, w_deliver;
  rr_pick4 u_pick (.ptr(r_ptr), .en(cfg_en), .pick(w_pick), .any(w_any));
  assign busy      = r_state == FULL;
  assign w_deliver = busy & out_ready[r_tgt];
  assign in_ready  = w_any & (~busy | out_ready[r_tgt]);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = busy ? onehot(r_tgt) : '0;
  assign out_data  = busy ? r_data : '0;
  assign out_sel   = busy ? r_tgt : '0;
  always_comb begin
    w_nstate = w_accept ? FULL : (w_deliver ? EMPTY : r_state);
  end
  // the held target is latched at accept, so mask changes never retarget it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_tgt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_accept) begin
        r_data <= in_data;
        r_tgt  <= w_pick;
        r_ptr  <= w_pick + SEL_W'(1);
      end
    end
  end
`ifdef DMUX4WAY_DISPATCH_CNT_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cnt <= '0;
      else if (cnt_clr) r_cnt <= '0;
      else if (w_deliver && r_tgt == SEL_W'(c) && r_cnt != '1) r_cnt <= r_cnt + CW'(1);
    end
    assign beat_cnt[c*CW +: CW] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_dmux4way_dispatch.sv
// tb_dmux4way_dispatch: table-driven and scoreboard bench for dmux4way_dispatch
// Counter checks are compiled in when DMUX4WAY_DISPATCH_CNT_EN is defined.
module tb_dmux4way_dispatch;
  localparam int W = 4;
  logic clk = 0, reset = 0, in_valid = 0;
  logic [3:0] cfg_en = 0, out_ready = 0, out_valid;
  logic [W-1:0] in_data = 0, out_data;
  logic in_ready, busy;
  logic [1:0] out_sel;
`ifdef DMUX4WAY_DISPATCH_CNT_EN
  logic [31:0] beat_cnt;
  logic cnt_clr = 0;
`endif
  always #5 clk = ~clk;
  dmux4way_dispatch #(.W(W), .CW(8)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_sel(out_sel), .busy(busy)
`ifdef DMUX4WAY_DISPATCH_CNT_EN
    , .beat_cnt(beat_cnt), .cnt_clr(cnt_clr)
`endif
  );
  typedef struct {bit rst; logic [3:0] en; logic [3:0] rdy; logic v; logic [W-1:0] d; int ch;} vec_t;
  typedef struct {int ch; logic [W-1:0] d;} exp_t;
  vec_t tbl[10];
  exp_t sb[$];
  int errors = 0, checks = 0;
  bit m_full = 0;
  logic [1:0] m_tgt = 0, m_ptr = 0;
  logic [W-1:0] m_data = 0;
  function automatic logic [1:0] mpick(input logic [1:0] p, input logic [3:0] en);
    for (int k = 0; k < 4; k++) if (en[2'(int'(p) + k)]) return 2'(int'(p) + k);
    return 2'd0;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 0;
    m_full = 0;
    m_ptr = 0;
    m_tgt = 0;
    sb.delete();
  endtask
  // one clock: drive at negedge, check just before the rising edge, advance model
  task automatic cycle(input logic [3:0] en, input logic [3:0] rdy, input logic v, input logic [W-1:0] d, input int ch);
    logic exp_rdy, del;
    logic [1:0] p;
    int got;
    exp_t e;
    cfg_en = en;
    out_ready = rdy;
    in_valid = v;
    in_data = d;
    #2;
    exp_rdy = (|en) && (!m_full || rdy[m_tgt]);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_full ? (4'b0001 << m_tgt) : 4'b0000);
    chk("out_data", out_data, m_full ? m_data : '0);
    chk("out_sel", out_sel, m_full ? m_tgt : 2'd0);
    chk("busy", busy, m_full);
    if (|(out_valid & out_ready)) begin
      got = 0;
      for (int k = 0; k < 4; k++) if (out_valid[k]) got = k;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: delivery on ch %0d data %0h, none expected", got, out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_ch", got, e.ch);
        chk("sb_data", out_data, e.d);
      end
    end
    del = m_full && rdy[m_tgt];
    if (v && exp_rdy) begin
      p = mpick(m_ptr, en);
      e.ch = (ch >= 0) ? ch : int'(p);
      e.d = d;
      sb.push_back(e);
      m_tgt = p;
      m_ptr = p + 2'd1;
      m_data = d;
      m_full = 1;
    end else if (del) m_full = 0;
    @(negedge clk);
  endtask
  initial begin
    tbl = '{
      '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 0},
      '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1},
      '{1'b0, 4'hF, 4'hF, 1'b1, 4'h3, 2},
      '{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 3},
      '{1'b0, 4'hF, 4'hF, 1'b1, 4'h5, 0},
      '{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, -1},
      '{1'b1, 4'h5, 4'hF, 1'b1, 4'h7, 0},
      '{1'b0, 4'h5, 4'hF, 1'b1, 4'h8, 2},
      '{1'b0, 4'h5, 4'hF, 1'b1, 4'h9, 0},
      '{1'b0, 4'h5, 4'hF, 1'b0, 4'h0, -1}
    };
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].en, tbl[i].rdy, tbl[i].v, tbl[i].d, tbl[i].ch);
    end
    do_reset();
    cycle(4'hF, 4'h0, 1, 4'hA, 0);
    #1;
    do_reset();
    cycle(4'hF, 4'hF, 0, 4'h0, -1);
    cycle(4'hF, 4'hF, 0, 4'h0, -1);
    do_reset();
    cycle(4'hF, 4'hF, 1, 4'h3, 0);
    cycle(4'hF, 4'h1, 1, 4'h6, 1);
    repeat (3) begin
      #1;
      chk("bp_out_valid", out_valid, 4'b0010);
      chk("bp_out_data", out_data, 4'h6);
      cycle(4'hF, 4'h1, 1, 4'hC, -1);
    end
    cycle(4'hF, 4'h2, 1, 4'hC, 2);
    cycle(4'hF, 4'hF, 0, 4'h0, -1);
    do_reset();
    cycle(4'hF, 4'hF, 1, 4'h1, 0);
    cycle(4'hF, 4'hF, 1, 4'h2, 1);
    cycle(4'hF, 4'hF, 1, 4'h3, 2);
    cycle(4'hF, 4'hF, 1, 4'h4, 3);
    cycle(4'h1, 4'h0, 0, 4'h0, -1);
    cycle(4'h1, 4'h8, 1, 4'hE, 0);
    cycle(4'h1, 4'h1, 0, 4'h0, -1);
    repeat (5) cycle(4'h0, 4'hF, 1, 4'h5, -1);
    cycle(4'hF, 4'hF, 1, 4'h5, 1);
    cycle(4'hF, 4'hF, 0, 4'h0, -1);
`ifdef DMUX4WAY_DISPATCH_CNT_EN
    do_reset();
    chk("cnt_rst", beat_cnt, 0);
    cycle(4'h4, 4'h4, 1, 4'h1, 2);
    cycle(4'h4, 4'h4, 0, 4'h0, 2);
    chk("cnt_one", beat_cnt, 32'h0001_0000);
    for (int i = 0; i < 300; i++) cycle(4'h4, 4'h4, 1, W'(i), 2);
    cycle(4'h4, 4'h4, 0, 4'h0, -1);
    chk("cnt_sat", beat_cnt, 32'h00FF_0000);
    cycle(4'h4, 4'h4, 1, 4'h2, 2);
    cnt_clr = 1;
    cycle(4'h4, 4'h4, 0, 4'h0, -1);
    cnt_clr = 0;
    chk("cnt_clr", beat_cnt, 0);
`endif
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
